// File: rtl/gf2_matvec_if.sv
// gf2_matvec_if: handshake and bus bundle for gf2_matvec_seq.
//   Matrix write port : mat_we, mat_row_idx, mat_row_data, mat_busy
//   Vector input      : in_valid, in_ready, in_vec, in_acc
//   Result output     : out_valid, out_ready, out_vec
// The master modport is the side driving vectors and row writes. The slave
// modport is the multiplier itself.
interface gf2_matvec_if #(
    parameter int N = 2
);
    localparam int IDX_W = $clog2(N);

    logic             mat_we;
    logic [IDX_W-1:0] mat_row_idx;
    logic [N-1:0]     mat_row_data;
    logic             mat_busy;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_vec;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_vec;

    modport master (
        output mat_we, mat_row_idx, mat_row_data, in_valid, in_vec, in_acc, out_ready,
        input  mat_busy, in_ready, out_valid, out_vec
    );

    modport slave (
        input  mat_we, mat_row_idx, mat_row_data, in_valid, in_vec, in_acc, out_ready,
        output mat_busy, in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/gf2_matvec_seq.sv
// gf2_matvec_seq: row-serial N x N matrix-vector multiplier over GF(2).
// It computes y = M v, or y = M v ^ y_prev in accumulate mode. Each clock
// produces one row result.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gf2_matvec_if.slave, which carries the matrix row writes,
//          the vector input handshake and the result output handshake
// Flow: IDLE accepts a vector. BUSY spends N edges filling the result
// register one row at a time. DONE holds the result until out_ready.
module gf2_matvec_seq #(
    parameter int N = 2
) (
    input  logic        clk,
    input  logic        rst,
    gf2_matvec_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [N-1:0][N-1:0]   m_q, m_d;      // m_q[i][j] = M[i][j]
    logic [N-1:0]          v_q, v_d;
    logic                  acc_q, acc_d;
    logic [IDX_W-1:0]      r_q, r_d;
    logic [N-1:0]          y_q, y_d;      // result register, drives out_vec
    logic [N-1:0]          yprev_q, yprev_d;
    logic                  wr_ok;
    logic                  row_bit;

    // Row writes land in IDLE and DONE only. Out-of-range rows (possible when
    // N is not a power of two) are dropped.
    assign wr_ok = bus.mat_we && (state_q != S_BUSY) &&
                   ({1'b0, bus.mat_row_idx} < (IDX_W + 1)'(N));

    // GF(2) dot product of the current row, plus the optional chain term.
    assign row_bit = (^(m_q[r_q] & v_q)) ^ (acc_q & yprev_q[r_q]);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        v_d     = v_q;
        acc_d   = acc_q;
        r_d     = r_q;
        y_d     = y_q;
        yprev_d = yprev_q;

        // A write on the accept edge is visible to the computation because the
        // first row is only evaluated on the following edge.
        if (wr_ok)
            m_d[bus.mat_row_idx] = bus.mat_row_data;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    v_d     = bus.in_vec;
                    acc_d   = bus.in_acc;
                    r_d     = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                y_d[r_q] = row_bit;
                r_d      = r_q + IDX_W'(1);
                if (r_q == IDX_W'(N - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                // Only results that were actually delivered feed the accumulate chain.
                if (bus.out_ready) begin
                    yprev_d = y_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            v_q     <= '0;
            acc_q   <= 1'b0;
            r_q     <= '0;
            y_q     <= '0;
            yprev_q <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            y_q     <= y_d;
            yprev_q <= yprev_d;
        end
    end

    // All handshake outputs are decoded from state alone, so there is no
    // combinational path from out_ready to in_ready.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.mat_busy  = (state_q == S_BUSY);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_vec   = y_q;
endmodule
